// File: rtl/board_writer.sv
`default_nettype none
// ============================================================================
// Module      : board_writer
// Description : Owner of the packed 64-square board register read by the
//               move scanners. Sweeps in the chess starting position, then
//               accepts move requests over valid/ready, validates them
//               (ownership, side to move, same-colour target) and applies
//               them with capture, pawn promotion and side-to-move toggle.
// Ports       : clk, rst                 - clock, sync active-high reset
//               init_req                 - restart starting-position sweep
//               move_valid/move_ready    - move request handshake
//               move_from/move_to        - source / destination square
//               bigBoard                 - board, square s at [4s+3:4s]
//               side_to_move             - 0 white, 1 black
//               captured_piece           - piece taken by last good move
//               move_done/move_error     - completion pulse and its status
//               busy                     - high in INIT, FETCH, COMMIT
// Revision    : 1.0 - initial release
// ============================================================================
module board_writer #(
    parameter bit         INIT_ON_RESET = 1'b1,
    parameter logic [2:0] PROMOTE_TO    = 3'd5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_req,
    input  logic         move_valid,
    output logic         move_ready,
    input  logic [5:0]   move_from,
    input  logic [5:0]   move_to,
    output logic [255:0] bigBoard,
    output logic         side_to_move,
    output logic [3:0]   captured_piece,
    output logic         move_done,
    output logic         move_error,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_FETCH  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t         state_q;
    logic [5:0]     cnt_q;
    logic [5:0]     from_q;
    logic [5:0]     to_q;
    logic [3:0]     p_q;
    logic [3:0]     q_q;
    logic           err_q;
    logic [255:0]   board_q;
    logic           stm_q;
    logic [3:0]     cap_q;
    logic           done_q;
    logic           merr_q;

    logic [3:0]     p_d;
    logic [3:0]     q_d;
    logic           err_d;
    logic           promote_d;
    logic [3:0]     dest_d;

    // Starting-position code for one square.
    function automatic logic [3:0] start_code(input logic [5:0] sq);
        logic [2:0] back;
        logic [3:0] code;
        back = 3'd0;
        code = 4'h0;
        case (sq[2:0])
            3'd0, 3'd7: back = 3'd4;
            3'd1, 3'd6: back = 3'd2;
            3'd2, 3'd5: back = 3'd3;
            3'd3:       back = 3'd5;
            default:    back = 3'd6;
        endcase
        case (sq[5:3])
            3'd0:    code = {1'b0, back};
            3'd1:    code = 4'h1;
            3'd6:    code = 4'h9;
            3'd7:    code = {1'b1, back};
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    always_comb begin
        p_d   = board_q[{from_q, 2'b00} +: 4];
        q_d   = board_q[{to_q, 2'b00} +: 4];
        // Checks are independent; any one of them rejects the move.
        err_d = (from_q == to_q)
             || (p_d == 4'h0)
             || (p_d[3] != stm_q)
             || ((q_d != 4'h0) && (q_d[3] == p_d[3]));
        // A pawn promotes on the far row for its own colour.
        promote_d = (p_q[2:0] == 3'd1)
                 && ((!p_q[3] && (to_q[5:3] == 3'd7))
                  || ( p_q[3] && (to_q[5:3] == 3'd0)));
        dest_d = promote_d ? {p_q[3], PROMOTE_TO} : p_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
            cnt_q   <= 6'd0;
            from_q  <= 6'd0;
            to_q    <= 6'd0;
            p_q     <= 4'h0;
            q_q     <= 4'h0;
            err_q   <= 1'b0;
            board_q <= '0;
            stm_q   <= 1'b0;
            cap_q   <= 4'h0;
            done_q  <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    board_q[{cnt_q, 2'b00} +: 4] <= start_code(cnt_q);
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        stm_q   <= 1'b0;
                        cap_q   <= 4'h0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (init_req) begin
                        cnt_q   <= 6'd0;
                        state_q <= ST_INIT;
                    end else if (move_valid) begin
                        from_q  <= move_from;
                        to_q    <= move_to;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    p_q     <= p_d;
                    q_q     <= q_d;
                    err_q   <= err_d;
                    state_q <= ST_COMMIT;
                end
                default: begin
                    done_q <= 1'b1;
                    merr_q <= err_q;
                    if (!err_q) begin
                        // from != to is guaranteed here, so the two writes
                        // never target the same nibble.
                        board_q[{from_q, 2'b00} +: 4] <= 4'h0;
                        board_q[{to_q, 2'b00} +: 4]   <= dest_d;
                        cap_q <= q_q;
                        stm_q <= ~stm_q;
                    end
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign move_ready     = (state_q == ST_IDLE) && !init_req;
    assign busy           = (state_q != ST_IDLE);
    assign bigBoard       = board_q;
    assign side_to_move   = stm_q;
    assign captured_piece = cap_q;
    assign move_done      = done_q;
    assign move_error     = merr_q;

endmodule
`default_nettype wire

// File: tb/tb_board_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_writer
// Description : Directed self-checking bench for board_writer. Main instance
//               starts from reset with the INIT sweep; a second instance
//               without the sweep covers reset during FETCH.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_writer;

    localparam logic [255:0] C_START = {32'hCABEDBAC, 32'h99999999, 128'h0,
                                        32'h11111111, 32'h42365324};

    logic         clk = 1'b0;
    logic         rst, init_req, move_valid;
    logic [5:0]   move_from, move_to;
    logic         move_ready, side_to_move, move_done, move_error, busy;
    logic [255:0] bigBoard;
    logic [3:0]   captured_piece;

    logic         rst0, init0, valid0;
    logic [5:0]   from0, to0;
    logic         ready0, stm0, done0, merr0, busy0;
    logic [255:0] board0;
    logic [3:0]   cap0;

    logic [255:0] exp_board;
    logic         exp_stm;
    logic [3:0]   exp_cap;
    int           n_checks = 0;
    int           n_pass   = 0;

    always #5 clk = ~clk;

    board_writer dut (
        .clk(clk), .rst(rst), .init_req(init_req), .move_valid(move_valid),
        .move_ready(move_ready), .move_from(move_from), .move_to(move_to),
        .bigBoard(bigBoard), .side_to_move(side_to_move),
        .captured_piece(captured_piece), .move_done(move_done),
        .move_error(move_error), .busy(busy)
    );

    board_writer #(.INIT_ON_RESET(1'b0), .PROMOTE_TO(3'd5)) dut0 (
        .clk(clk), .rst(rst0), .init_req(init0), .move_valid(valid0),
        .move_ready(ready0), .move_from(from0), .move_to(to0),
        .bigBoard(board0), .side_to_move(stm0),
        .captured_piece(cap0), .move_done(done0),
        .move_error(merr0), .busy(busy0)
    );

    task automatic chk_eq(input string tag, input logic [255:0] act,
                          input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic set_sq(input int sq, input logic [3:0] code);
        exp_board[sq*4 +: 4] = code;
    endtask

    // Issue one move from IDLE (called #1 after an edge) and check the
    // outcome one step after E2, then the pulse clearing after E3.
    task automatic do_move(input string tag, input logic [5:0] f,
                           input logic [5:0] t, input logic exp_err);
        chk_eq({tag, " ready"}, 256'(move_ready), 256'(1'b1));
        move_valid = 1'b1;
        move_from  = f;
        move_to    = t;
        @(posedge clk); #1;
        move_valid = 1'b0;
        chk_eq({tag, " busy_fetch"}, 256'(busy), 256'(1'b1));
        @(posedge clk); #1;
        chk_eq({tag, " no_early_done"}, 256'(move_done), 256'(1'b0));
        @(posedge clk); #1;
        chk_eq({tag, " done"}, 256'(move_done), 256'(1'b1));
        chk_eq({tag, " error"}, 256'(move_error), 256'(exp_err));
        chk_eq({tag, " board"}, bigBoard, exp_board);
        chk_eq({tag, " stm"}, 256'(side_to_move), 256'(exp_stm));
        chk_eq({tag, " cap"}, 256'(captured_piece), 256'(exp_cap));
        chk_eq({tag, " ready_again"}, 256'(move_ready), 256'(1'b1));
        @(posedge clk); #1;
        chk_eq({tag, " done_low"}, 256'(move_done), 256'(1'b0));
        chk_eq({tag, " error_hold"}, 256'(move_error), 256'(exp_err));
    endtask

    initial begin
        rst = 1'b1; init_req = 1'b0; move_valid = 1'b0;
        move_from = 6'd0; move_to = 6'd0;
        rst0 = 1'b1; init0 = 1'b0; valid0 = 1'b0; from0 = 6'd0; to0 = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst board", bigBoard, 256'h0);
        chk_eq("rst stm", 256'(side_to_move), 256'(1'b0));
        chk_eq("rst cap", 256'(captured_piece), 256'h0);
        chk_eq("rst done", 256'(move_done), 256'(1'b0));
        chk_eq("rst err", 256'(move_error), 256'(1'b0));
        chk_eq("rst busy_init", 256'(busy), 256'(1'b1));
        chk_eq("rst ready", 256'(move_ready), 256'(1'b0));
        chk_eq("rst0 board", board0, 256'h0);
        chk_eq("rst0 idle", 256'(busy0), 256'(1'b0));
        rst  = 1'b0;
        rst0 = 1'b0;

        // Sweep: 63 writes leave square 63 empty and busy still high.
        repeat (63) @(posedge clk);
        #1;
        chk_eq("init busy63", 256'(busy), 256'(1'b1));
        chk_eq("init board63", bigBoard, C_START & ~(256'hF << 252));
        @(posedge clk); #1;
        chk_eq("init busy64", 256'(busy), 256'(1'b0));
        chk_eq("init board", bigBoard, C_START);
        chk_eq("init stm", 256'(side_to_move), 256'(1'b0));

        exp_board = C_START; exp_stm = 1'b0; exp_cap = 4'h0;

        set_sq(12, 4'h0); set_sq(28, 4'h1); exp_stm = 1'b1;
        do_move("m12_28", 6'd12, 6'd28, 1'b0);
        do_move("empty_src", 6'd12, 6'd20, 1'b1);
        do_move("same_sq", 6'd8, 6'd8, 1'b1);
        do_move("wrong_side", 6'd11, 6'd19, 1'b1);
        set_sq(51, 4'h0); set_sq(35, 4'h9); exp_stm = 1'b0;
        do_move("m51_35", 6'd51, 6'd35, 1'b0);
        set_sq(1, 4'h0); set_sq(18, 4'h2); exp_stm = 1'b1;
        do_move("m1_18", 6'd1, 6'd18, 1'b0);
        set_sq(48, 4'h0); set_sq(40, 4'h9); exp_stm = 1'b0;
        do_move("m48_40", 6'd48, 6'd40, 1'b0);
        set_sq(18, 4'h0); set_sq(35, 4'h2); exp_stm = 1'b1; exp_cap = 4'h9;
        do_move("capture", 6'd18, 6'd35, 1'b0);
        do_move("own_target", 6'd56, 6'd57, 1'b1);
        set_sq(62, 4'h0); set_sq(45, 4'hA); exp_stm = 1'b0; exp_cap = 4'h0;
        do_move("m62_45", 6'd62, 6'd45, 1'b0);
        set_sq(14, 4'h0); set_sq(54, 4'h1); exp_stm = 1'b1; exp_cap = 4'h9;
        do_move("m14_54", 6'd14, 6'd54, 1'b0);
        set_sq(49, 4'h0); set_sq(41, 4'h9); exp_stm = 1'b0; exp_cap = 4'h0;
        do_move("m49_41", 6'd49, 6'd41, 1'b0);
        set_sq(54, 4'h0); set_sq(62, 4'h5); exp_stm = 1'b1;
        do_move("promo_w", 6'd54, 6'd62, 1'b0);
        set_sq(50, 4'h0); set_sq(3, 4'hD); exp_stm = 1'b0; exp_cap = 4'h5;
        do_move("promo_b", 6'd50, 6'd3, 1'b0);

        // init_req beats move_valid in the same cycle.
        init_req = 1'b1; move_valid = 1'b1; move_from = 6'd8; move_to = 6'd16;
        #1;
        chk_eq("initreq ready", 256'(move_ready), 256'(1'b0));
        @(posedge clk); #1;
        init_req = 1'b0; move_valid = 1'b0;
        chk_eq("initreq busy", 256'(busy), 256'(1'b1));
        @(posedge clk); #1;
        chk_eq("initreq nodone1", 256'(move_done), 256'(1'b0));
        @(posedge clk); #1;
        chk_eq("initreq nodone2", 256'(move_done), 256'(1'b0));
        repeat (62) @(posedge clk);
        #1;
        chk_eq("reinit busy", 256'(busy), 256'(1'b0));
        chk_eq("reinit board", bigBoard, C_START);
        chk_eq("reinit stm", 256'(side_to_move), 256'(1'b0));
        chk_eq("reinit cap", 256'(captured_piece), 256'h0);

        // Reset while the no-sweep instance sits in FETCH.
        chk_eq("r0 ready", 256'(ready0), 256'(1'b1));
        valid0 = 1'b1; from0 = 6'd0; to0 = 6'd1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        chk_eq("r0 fetch", 256'(busy0), 256'(1'b1));
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        chk_eq("r0 idle", 256'(busy0), 256'(1'b0));
        chk_eq("r0 board", board0, 256'h0);
        chk_eq("r0 nodone0", 256'(done0), 256'(1'b0));
        @(posedge clk); #1;
        chk_eq("r0 nodone1", 256'(done0), 256'(1'b0));
        @(posedge clk); #1;
        chk_eq("r0 nodone2", 256'(done0), 256'(1'b0));
        chk_eq("r0 stay_idle", 256'(busy0), 256'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_writer.md
Name: board_writer

Overview:
- Owns the 256-bit packed board register (`bigBoard`) that the move scanners read.
- Fills the board with the chess starting position, then accepts move requests over a valid/ready handshake.
- Each move is validated, then applied: capture, pawn promotion and side-to-move toggle.
- Sits between game-control logic (the move initiator) and the piece-scan logic (the readers of `bigBoard`).

Parameters:
- `INIT_ON_RESET`, default 1: 1 = enter the INIT sweep automatically when reset deasserts; 0 = stay in IDLE with an empty board.
- `PROMOTE_TO`, default 3'd5: piece type a pawn becomes on reaching the last row (5 = queen).

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `init_req` input 1: in IDLE, restart the starting-position sweep.
- `move_valid` input 1: move request present.
- `move_ready` output 1: block can accept a move; combinational = (state==IDLE) && !init_req.
- `move_from` input 6: source square.
- `move_to` input 6: destination square.
- `bigBoard` output 256: board; square s occupies bits [4s+3:4s]; row = s/8, col = s%8.
- `side_to_move` output 1: 0 white, 1 black.
- `captured_piece` output 4: piece that was on `move_to` for the last committed move; 0 if none.
- `move_done` output 1: one-cycle pulse, move finished (applied or rejected).
- `move_error` output 1: qualifies `move_done`; 1 = rejected, board unchanged.
- `busy` output 1: high in INIT, FETCH, COMMIT.

Behaviour:
- Piece code: bit3 = colour (0 white, 1 black); bits[2:0] = type: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king. Code 4'h0 = empty square.
- Starting position:
  - Row 0 (squares 0–7): white R N B Q K B N R = 4,2,3,5,6,3,2,4.
  - Row 1: white pawns (4'h1).
  - Rows 2–5: empty.
  - Row 6: black pawns (4'h9).
  - Row 7: black C A B D E B A C (4'hC, 4'hA, 4'hB, 4'hD, 4'hE, 4'hB, 4'hA, 4'hC).
- Reset (rst=1 at an edge):
  - `bigBoard`=0, `side_to_move`=0, `captured_piece`=0, `move_done`=0, `move_error`=0.
  - Square counter = 0.
  - State = INIT if `INIT_ON_RESET`=1, else IDLE.
  - Reset overrides any state mid-operation; no `move_done` pulse is produced for an aborted move.
- States: INIT, IDLE, FETCH, COMMIT.
- INIT:
  - Writes one square per cycle: counter 0..63, square[counter] <= start code.
  - After writing square 63: `side_to_move`<=0, `captured_piece`<=0, go to IDLE.
  - Sweep length is 64 cycles. `move_ready`=0 throughout.
- IDLE:
  - `init_req`=1 → counter<=0, go to INIT. This takes priority over `move_valid` the same cycle (`move_ready` is 0 then).
  - Otherwise `move_valid` && `move_ready` at an edge → latch `move_from`/`move_to`, go to FETCH.
  - Inputs are not sampled after acceptance.
- FETCH (one cycle): latch P = board[from] and Q = board[to], then evaluate errors in this order:
  - from==to → error.
  - P==0 → error.
  - P[3] != `side_to_move` → error.
  - Q!=0 && Q[3]==P[3] → error.
  - Go to COMMIT.
- COMMIT (one cycle), then IDLE.
  - On error: `move_done`<=1, `move_error`<=1; board, `side_to_move` and `captured_piece` unchanged.
  - Else, in the same edge:
    - board[from]<=0.
    - board[to]<=P, or {P[3], `PROMOTE_TO`} when P is a pawn landing on row 7 (white) or row 0 (black).
    - `captured_piece`<=Q.
    - `side_to_move`<=~`side_to_move`.
    - `move_done`<=1, `move_error`<=0.
- Timing:
  - Accept at edge E0; FETCH evaluated at E1; COMMIT at E2.
  - `move_done` and the new `bigBoard` are visible in the same cycle after E2; `move_done` is low after E3.
  - `move_ready` is high again after E2.
  - Maximum throughput: one move per 3 cycles.
- `move_error` holds its value until the next `move_done`. `move_done` is otherwise 0.
- Legality of piece movement geometry (knight offsets, sliding, check) is NOT checked here; that belongs to the scan/generation logic.

Test Plan:
- Reset with `INIT_ON_RESET`=1, run 64 cycles → `bigBoard`[3:0]=4'h4, [19:16]=4'h6 (sq4), [255:252]=4'hC, [135:128]=0; `busy` falls on cycle 65; `side_to_move`=0.
- Move 12→28 (white pawn) → at E2+: sq12=0, sq28=4'h1, `move_done`=1 for one cycle, `move_error`=0, `side_to_move`=1, `captured_piece`=0.
- Then 12→20 (empty source) → `move_done`=1, `move_error`=1, board unchanged; the same happens for 8→8 (from==to) and for white moving on black's turn.
- Capture: preload via a move sequence so black 4'h9 sits on sq35 and a white knight moves onto it → `captured_piece`=4'h9, sq35=4'h2. Same-colour target → `move_error`=1.
- White pawn 54→62 after sq62 has been cleared → sq62=4'h5 (promotion); black pawn reaching row 0 → 4'hD.
- Edge cases:
  - `init_req` and `move_valid` high together in IDLE → INIT entered, move not accepted.
  - `rst` asserted during FETCH → board=0 (`INIT_ON_RESET`=0), no `move_done` pulse.
